dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder on the memory side of the MEM-stage data port. It accepts one read or write request at a time from the pipeline, holds the pipeline with `Stall` while the access is in flight, and completes after a fixed `LATENCY` with a one-cycle `Done` pulse. Read data is registered on `DataOut`. Storage is a word array addressed by byte address, and the block checks each request for alignment and for a legal read/write combination.

## Interface
Parameters:
- `LATENCY`, default 4: cycles from request acceptance to `Done`. Legal range is 1 to 15.
- `DEPTH_LOG2`, default 13: log2 of the number of 16-bit words stored (8K words).

Ports:
- `clk`, in, 1: single clock. All state updates on the rising edge.
- `rst`, in, 1: reset. Synchronous, active-low.
- `Rd`, in, 1: read request.
- `Wr`, in, 1: write request.
- `Addr`, in, 16: byte address.
- `DataIn`, in, 16: write data.
- `Halt`, in, 1: processor halted. Blocks new requests.
- `DataOut`, out, 16: registered read data.
- `Stall`, out, 1: access in flight. The pipeline must hold the MEM stage while this is high.
- `Done`, out, 1: one-cycle completion pulse.
- `Err`, out, 1: one-cycle pulse flagging a rejected request.

## Operation
- **States:**
  - `IDLE`: no access in progress.
  - `BUSY`: access in flight. A 4-bit down-counter runs.
  - `DONE`: completion cycle.
- **Valid request:**
  - Condition: `(Rd ^ Wr) & ~Halt & ~Addr[0]`, sampled in `IDLE` or `DONE`.
  - Action: capture op, `Addr[DEPTH_LOG2:1]` as the word index, and `DataIn`.
  - Next state: `BUSY` with counter = `LATENCY-1`. If `LATENCY` = 1, go directly to `DONE`.
- **Address wrap:** `Addr` bits above `DEPTH_LOG2` are ignored, so addresses wrap modulo 2^(`DEPTH_LOG2`+1) bytes.
- **Error request:**
  - Condition: `(Rd & Wr)`, or `(Rd | Wr) & Addr[0]`, with `~Halt`, sampled in `IDLE` or `DONE`.
  - Response: `Err` goes high for one cycle on the next cycle. No access, no `Stall`, `DataOut` unchanged.
  - Next state: `IDLE`.
- **BUSY:**
  - Counter decrements each cycle. At zero, the next state is `DONE`.
  - `Rd`, `Wr`, `Addr` and `DataIn` are ignored while in `BUSY`, because the captured copies are used.
- **Commit on entry to DONE:**
  - A write updates the array word.
  - A read loads `DataOut` from the array word.
- **DONE:**
  - `Done` = 1 and `Stall` = 0.
  - A valid request in this cycle is accepted back-to-back, with no idle bubble.
  - Otherwise the next state is `IDLE`.
- **`DataOut`:** holds the last completed read. Writes never change it.
- **Halt:** blocks new acceptance only. An in-flight access still completes and pulses `Done`.
- **Reset:**
  - Applied on any edge with `rst` = 0: state goes to `IDLE`, counter to 0, `DataOut` to 0x0000, and `Done`, `Err` and `Stall` go low.
  - Reset mid-operation aborts the access. An uncommitted write is discarded.
  - Array contents are not cleared by reset.

## Timing
- **Request timing:** a request is presented in cycle N and sampled at the end of cycle N.
- **`Stall`:** combinational.
  - High in cycle N when a valid request is seen in `IDLE` or `DONE`.
  - Registered high for the cycles N+1 .. N+LATENCY-1.
  - Total: `Stall` is high for exactly `LATENCY` cycles (N .. N+LATENCY-1).
- **`Done`:** high in cycle N+LATENCY only.
- **`DataOut`:** valid from cycle N+LATENCY and held until the next read completes.
- **`Err`:** high in cycle N+1 for an error request made in cycle N.
- **Throughput:** one access per `LATENCY` cycles when requests are issued in the `Done` cycle.

## Test plan
- **Reset values:** hold `rst` = 0 for 2 cycles with `Rd` = 1. Required: `Stall` = 0, `Done` = 0, `Err` = 0, `DataOut` = 0x0000 throughout.
- **Write then read (`LATENCY` = 4):**
  - Write 0xBEEF to 0x0010 at cycle N. Required: `Stall` high for N..N+3 and `Done` at N+4.
  - Read 0x0010. Required: `Done` 4 cycles later and `DataOut` = 0xBEEF.
- **Back-to-back requests:** issue a read of 0x0010 during a write's `Done` cycle. Required: the read is accepted with no bubble, `Done` again 4 cycles later, and `DataOut` = 0xBEEF.
- **Rejected requests:**
  - `Rd` = 1 with `Addr` = 0x0011. Required: `Err` = 1 for one cycle, `Stall` = 0, no `Done`, `DataOut` unchanged.
  - `Rd` = `Wr` = 1. Required: same response.
  - `Halt` = 1 with `Rd` = 1. Required: no `Stall`, no `Done`, no `Err`.
- **Address wrap (`DEPTH_LOG2` = 13):** write 0x1234 to 0x4002, then read 0x0002. Required: `DataOut` = 0x1234.
- **Reset mid-write:** with 0x0020 holding 0xAAAA, start a write of 0x5555 to 0x0020 and drop `rst` at N+2. Required: no `Done`, `Stall` = 0 after the reset edge, and a later read of 0x0020 returns 0xAAAA.

Source files
------------

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data-memory responder for the MEM-stage data port. It accepts
// one read or write at a time. While the access is in flight it holds the
// pipeline with Stall. After LATENCY cycles it signals completion with a
// one-cycle Done pulse. Read data is registered on DataOut. Requests that are
// misaligned, or that assert Rd and Wr together, are rejected with a
// one-cycle Err pulse.
//
// Parameters:
//   LATENCY     cycles from request acceptance to Done (1..15)
//   DEPTH_LOG2  log2 of the number of 16-bit words stored
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst      in   1  synchronous active-low reset
//   Rd       in   1  read request
//   Wr       in   1  write request
//   Addr     in  16  byte address (bits above DEPTH_LOG2 ignored)
//   DataIn   in  16  write data
//   Halt     in   1  processor halted, blocks new requests
//   DataOut  out 16  last completed read data
//   Stall    out  1  access in flight, pipeline must hold MEM
//   Done     out  1  one-cycle completion pulse
//   Err      out  1  one-cycle rejected-request pulse
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned DEPTH_LOG2 = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Rd,
    input  logic        Wr,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Halt,
    output logic [15:0] DataOut,
    output logic        Stall,
    output logic        Done,
    output logic        Err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned WORDS    = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [15:0]             dout_q;
    logic                    err_q, err_d;

    logic [15:0]             mem [WORDS];

    logic                    window;
    logic                    valid_req;
    logic                    err_req;
    logic                    stall_c;
    logic                    commit_en;
    logic                    commit_we;
    logic [DEPTH_LOG2-1:0]   commit_idx;
    logic [15:0]             commit_data;
    logic [DEPTH_LOG2-1:0]   req_idx;

    // Upper address bits only feed the wrap-around; fold them into a sink.
    logic                    unused_addr;
    assign unused_addr = ^Addr;

    // Word index drops the byte bit and everything above the array size,
    // which is what makes addresses wrap.
    assign req_idx = Addr[DEPTH_LOG2:1];

    // New requests are sampled whenever no access is counting down, which
    // includes the Done cycle so back-to-back accesses have no bubble.
    assign window    = (state_q != BUSY);
    assign valid_req = window & (Rd ^ Wr) & ~Halt & ~Addr[0];
    assign err_req   = window & ~Halt & ((Rd & Wr) | ((Rd | Wr) & Addr[0]));

    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        err_d       = 1'b0;
        stall_c     = 1'b0;
        commit_en   = 1'b0;
        commit_we   = we_q;
        commit_idx  = idx_q;
        commit_data = wdata_q;

        unique case (state_q)
            BUSY: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                // Counter reaching zero on this edge means the commit edge.
                if (cnt_q == 4'd1) begin
                    state_d   = DONE;
                    commit_en = 1'b1;
                end
            end
            IDLE, DONE: begin
                state_d = IDLE;
                if (valid_req) begin
                    stall_c = 1'b1;
                    we_d    = Wr;
                    idx_d   = req_idx;
                    wdata_d = DataIn;
                    if (LATENCY == 1) begin
                        // Single-cycle access commits straight from the
                        // request lines, there is no BUSY phase.
                        state_d     = DONE;
                        cnt_d       = 4'd0;
                        commit_en   = 1'b1;
                        commit_we   = Wr;
                        commit_idx  = req_idx;
                        commit_data = DataIn;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
                err_d = err_req;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            dout_q  <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (commit_en && !commit_we) begin
                dout_q <= mem[commit_idx];
            end
        end
    end

    // Captured request copies are only read after acceptance, so they need
    // no reset value.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    // NOTE: the storage array has no reset; contents survive rst, and only
    // the commit enable is gated so an aborted write never lands.
    always_ff @(posedge clk) begin
        if (rst && commit_en && commit_we) begin
            mem[commit_idx] <= commit_data;
        end
    end

    assign Stall   = rst & stall_c;
    assign Done    = (state_q == DONE);
    assign Err     = err_q;
    assign DataOut = dout_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed stimulus for dmem_responder (LATENCY=4, DEPTH_LOG2=13). A
// cycle-stamped reference model predicts Stall/Done/Err/DataOut from the
// request timing rules and is compared every cycle; hand-computed literal
// expectations pin the model at the key points.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int LAT   = 4;
    localparam int DLOG2 = 13;
    localparam int WORDS = 2 ** DLOG2;

    logic        clk;
    logic        rst;
    logic        Rd;
    logic        Wr;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Halt;
    logic [15:0] DataOut;
    logic        Stall;
    logic        Done;
    logic        Err;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (DLOG2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .Rd      (Rd),
        .Wr      (Wr),
        .Addr    (Addr),
        .DataIn  (DataIn),
        .Halt    (Halt),
        .DataOut (DataOut),
        .Stall   (Stall),
        .Done    (Done),
        .Err     (Err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: an accepted request in cycle N keeps Stall high for
    // N..N+LAT-1, pulses Done in N+LAT and commits on the edge into N+LAT.
    // An error request in cycle N pulses Err in N+1.
    // -----------------------------------------------------------------------
    int          cyc      = 1;
    bit          act      = 1'b0;
    int          done_cyc = -1;
    int          err_cyc  = -1;
    bit          a_we;
    int          a_idx;
    logic [15:0] a_data;
    logic [15:0] dout_m   = 16'h0000;
    logic [15:0] mem_m [int];

    always @(negedge clk) begin
        bit in_flight, free, v, e;
        in_flight = act && (cyc < done_cyc);
        free      = !in_flight;
        v = rst && free && (Rd ^ Wr) && !Halt && !Addr[0];
        e = rst && free && !Halt && ((Rd && Wr) || ((Rd || Wr) && Addr[0]));

        check("m_stall", 16'(Stall), 16'(rst && (in_flight || v)));
        check("m_done",  16'(Done),  16'(act && (cyc == done_cyc)));
        check("m_err",   16'(Err),   16'(err_cyc == cyc));
        check("m_dout",  DataOut,    dout_m);

        if (!rst) begin
            act      = 1'b0;
            done_cyc = -1;
            err_cyc  = -1;
            dout_m   = 16'h0000;
        end else begin
            if (v) begin
                act      = 1'b1;
                done_cyc = cyc + LAT;
                a_we     = Wr;
                a_idx    = (int'(Addr) / 2) % WORDS;
                a_data   = DataIn;
            end
            if (e) err_cyc = cyc + 1;
            if (act && (done_cyc == cyc + 1)) begin
                if (a_we) mem_m[a_idx] = a_data;
                else dout_m = mem_m.exists(a_idx) ? mem_m[a_idx] : 16'hxxxx;
            end
        end
        cyc++;
    end

    // One call = one cycle of inputs, applied just after the rising edge.
    task automatic step(input logic r, input logic rd, input logic wr, input logic h,
                        input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        rst = r; Rd = rd; Wr = wr; Halt = h; Addr = a; DataIn = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; Rd = 1'b1; Wr = 1'b0; Halt = 1'b0; Addr = 16'h0010; DataIn = 16'h0000;

        // Reset held two cycles with Rd asserted (cycles 1, 2).
        @(negedge clk);
        check("rst1_stall", 16'(Stall), 16'h0);
        check("rst1_done",  16'(Done),  16'h0);
        check("rst1_err",   16'(Err),   16'h0);
        check("rst1_dout",  DataOut,    16'h0000);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk);
        check("rst2_stall", 16'(Stall), 16'h0);
        check("rst2_dout",  DataOut,    16'h0000);
        idle(1);

        // Write 0xBEEF to 0x0010 in cycle N=4: Stall 4..7, Done at 8.
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF);
        @(negedge clk);
        check("wr_stall_n", 16'(Stall), 16'h1);
        idle(3);
        @(negedge clk);
        check("wr_stall_n3", 16'(Stall), 16'h1);
        idle(1);
        @(negedge clk);
        check("wr_done_n4",  16'(Done),  16'h1);
        check("wr_stall_n4", 16'(Stall), 16'h0);

        // Read 0x0010 in cycle 9: Done at 13 with 0xBEEF.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        idle(4);
        @(negedge clk);
        check("rd_done", 16'(Done), 16'h1);
        check("rd_data", DataOut,   16'hBEEF);

        // Back-to-back: write at 14, read issued in its Done cycle 18.
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF);
        idle(3);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        @(negedge clk);
        check("b2b_wr_done",   16'(Done),  16'h1);
        check("b2b_rd_stall",  16'(Stall), 16'h1);
        idle(4);
        @(negedge clk);
        check("b2b_rd_done", 16'(Done), 16'h1);
        check("b2b_rd_data", DataOut,   16'hBEEF);

        // Misaligned read in cycle 23: Err at 24 only.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0011, 16'h0000);
        @(negedge clk);
        check("mis_stall", 16'(Stall), 16'h0);
        idle(1);
        @(negedge clk);
        check("mis_err",  16'(Err),  16'h1);
        check("mis_done", 16'(Done), 16'h0);
        check("mis_dout", DataOut,   16'hBEEF);
        idle(1);
        @(negedge clk);
        check("mis_err_gone", 16'(Err), 16'h0);

        // Rd and Wr together in cycle 26: Err at 27.
        step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h1111);
        idle(1);
        @(negedge clk);
        check("rdwr_err",   16'(Err),   16'h1);
        check("rdwr_stall", 16'(Stall), 16'h0);
        idle(1);
        @(negedge clk);
        check("rdwr_err_gone", 16'(Err), 16'h0);

        // Halted read (29, 30): nothing happens.
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
        @(negedge clk);
        check("halt_stall", 16'(Stall), 16'h0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
        @(negedge clk);
        check("halt_err",  16'(Err),  16'h0);
        check("halt_done", 16'(Done), 16'h0);

        // Read at 31, Halt raised while in flight: still completes at 35.
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
        @(negedge clk);
        check("halt_fl_done",  16'(Done),  16'h1);
        check("halt_fl_stall", 16'(Stall), 16'h0);
        idle(1);

        // Address wrap: write 0x1234 to 0x4002 (37), read 0x0002 (42).
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h4002, 16'h1234);
        idle(4);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000);
        idle(4);
        @(negedge clk);
        check("wrap_done", 16'(Done), 16'h1);
        check("wrap_data", DataOut,   16'h1234);

        // 0x0020 <= 0xAAAA (47), then write 0x5555 (52) aborted by reset at 54.
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 16'hAAAA);
        idle(4);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h5555);
        idle(1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        idle(1);
        @(negedge clk);
        check("abort_stall", 16'(Stall), 16'h0);
        check("abort_done",  16'(Done),  16'h0);
        idle(1);
        @(negedge clk);
        check("abort_no_done", 16'(Done), 16'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        idle(4);
        @(negedge clk);
        check("abort_rd_done", 16'(Done), 16'h1);
        check("abort_rd_data", DataOut,   16'hAAAA);

        idle(3);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
